// File: rtl/mem_copy_engine_pkg.sv
// Shared constants and state encoding for the block copy/fill engine.
package mem_pkg;
    localparam int AW             = 10;
    localparam int DW             = 32;
    localparam int LW             = 8;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;
endpackage

// File: rtl/mem_copy_engine.sv
// Memory copy/fill initiator: COPY alternates one read and one write per word, FILL writes every cycle.
// Commands are latched on an accepted start; later input changes and starts are ignored until IDLE.
module mem_copy_engine
    import mem_pkg::*;
#(
    parameter int AW = mem_pkg::AW,
    parameter int DW = mem_pkg::DW,
    parameter int LW = mem_pkg::LW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [LW-1:0] len,
    input  logic [DW-1:0] fill_data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          mem_write,
    output logic          mem_read,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wrdata,
    input  logic [DW-1:0] mem_rddata
);

    localparam int XW = 12;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] src_ptr;
    logic [AW-1:0] dst_ptr;
    logic [LW-1:0] cnt;
    logic [DW-1:0] rd_buf;
    logic [DW-1:0] fill_q;
    logic          mode_q;
    logic          err_q;

    logic [XW-1:0] span;
    logic [XW-1:0] dst_end;
    logic [XW-1:0] src_end;
    logic          range_bad;
    logic          accept;

    // End addresses are computed one past the last byte, so touching 2^AW-1 exactly is legal.
    assign span      = XW'(len) << 2;
    assign dst_end   = XW'(dst_addr) + span;
    assign src_end   = XW'(src_addr) + span;
    assign range_bad = (len != '0) &&
                       ((dst_end > XW'(1 << AW)) ||
                        ((mode == MODE_COPY) && (src_end > XW'(1 << AW))));
    assign accept    = (state == IDLE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start && !range_bad) begin
                    if (len == '0) begin
                        state_nx = FIN;
                    end else if (mode == MODE_FILL) begin
                        state_nx = WR;
                    end else begin
                        state_nx = RD;
                    end
                end
            end
            RD:  state_nx = WR;
            WR: begin
                if (cnt == LW'(1)) begin
                    state_nx = FIN;
                end else if (mode_q == MODE_FILL) begin
                    state_nx = WR;
                end else begin
                    state_nx = RD;
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wrdata = '0;
        case (state)
            RD: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                mem_addr = src_ptr;
            end
            WR: begin
                busy       = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = dst_ptr;
                mem_wrdata = (mode_q == MODE_FILL) ? fill_q : rd_buf;
            end
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

    assign err = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_ptr <= '0;
            dst_ptr <= '0;
            cnt     <= '0;
            rd_buf  <= '0;
            fill_q  <= '0;
            mode_q  <= MODE_COPY;
            err_q   <= 1'b0;
        end else begin
            err_q <= accept && range_bad;
            if (accept) begin
                src_ptr <= src_addr;
                dst_ptr <= dst_addr;
                cnt     <= len;
                mode_q  <= mode;
                fill_q  <= fill_data;
            end
            if (state == RD) begin
                rd_buf  <= mem_rddata;
                src_ptr <= src_ptr + AW'(BYTES_PER_WORD);
            end
            if (state == WR) begin
                dst_ptr <= dst_ptr + AW'(BYTES_PER_WORD);
                cnt     <= cnt - LW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: byte-array memory responder plus a word-level reference model.
module tb_mem_copy_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [9:0]  src_addr = '0;
    logic [9:0]  dst_addr = '0;
    logic [7:0]  len = '0;
    logic [31:0] fill_data = '0;
    logic        busy, done, err, mem_write, mem_read;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wrdata, mem_rddata;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem     [1024];
    logic [7:0]  ref_mem [1024];
    logic        tb_we = 1'b0;
    logic [9:0]  tb_addr = '0;
    logic [31:0] tb_dat = '0;

    mem_copy_engine dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_data(fill_data),
        .busy(busy), .done(done), .err(err),
        .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
        .mem_wrdata(mem_wrdata), .mem_rddata(mem_rddata)
    );

    always #5 clk = ~clk;

    assign mem_rddata = {mem[mem_addr + 10'd3], mem[mem_addr + 10'd2],
                         mem[mem_addr + 10'd1], mem[mem_addr]};

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr]         <= mem_wrdata[7:0];
            mem[mem_addr + 10'd1] <= mem_wrdata[15:8];
            mem[mem_addr + 10'd2] <= mem_wrdata[23:16];
            mem[mem_addr + 10'd3] <= mem_wrdata[31:24];
        end else if (tb_we) begin
            mem[tb_addr]         <= tb_dat[7:0];
            mem[tb_addr + 10'd1] <= tb_dat[15:8];
            mem[tb_addr + 10'd2] <= tb_dat[23:16];
            mem[tb_addr + 10'd3] <= tb_dat[31:24];
        end
    end

    task automatic chk(input string tag, input logic [46:0] obs, input logic [46:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [46:0] ev(input bit b, input bit d, input bit e, input bit r,
                                       input bit w, input logic [9:0] a, input logic [31:0] dat);
        return {b, d, e, r, w, a, dat};
    endfunction

    // Address/data only matter while a strobe is up.
    function automatic logic [46:0] obs_vec();
        logic [9:0]  a;
        logic [31:0] d;
        a = (mem_read || mem_write) ? mem_addr : 10'd0;
        d = mem_write ? mem_wrdata : 32'd0;
        return {busy, done, err, mem_read, mem_write, a, d};
    endfunction

    function automatic logic [31:0] ref_rd(input logic [9:0] a);
        return {ref_mem[a + 10'd3], ref_mem[a + 10'd2], ref_mem[a + 10'd1], ref_mem[a]};
    endfunction

    function automatic void ref_wr(input logic [9:0] a, input logic [31:0] w);
        ref_mem[a]         = w[7:0];
        ref_mem[a + 10'd1] = w[15:8];
        ref_mem[a + 10'd2] = w[23:16];
        ref_mem[a + 10'd3] = w[31:24];
    endfunction

    function automatic logic [31:0] mem_rd(input logic [9:0] a);
        return {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
    endfunction

    task automatic poke(input logic [9:0] a, input logic [31:0] w);
        tb_addr = a;
        tb_dat  = w;
        tb_we   = 1'b1;
        ref_wr(a, w);
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic junk();
        start     = 1'($urandom_range(0, 1));
        mode      = 1'($urandom_range(0, 1));
        src_addr  = 10'($urandom);
        dst_addr  = 10'($urandom);
        len       = 8'($urandom);
        fill_data = $urandom;
    endtask

    task automatic mem_cmp(input string tag);
        int diffs = 0;
        for (int i = 0; i < 1024; i++) begin
            if (mem[i] !== ref_mem[i]) diffs++;
        end
        chk(tag, 47'(diffs), 47'd0);
    endtask

    task automatic run_cmd(input string tag, input bit m, input logic [9:0] s,
                           input logic [9:0] d, input logic [7:0] l, input logic [31:0] f);
        logic [46:0] q[$];
        logic [31:0] w;
        bit          range_bad;
        range_bad = (l != 0) && ((int'(d) + 4 * int'(l) > 1024) ||
                                 (m == 1'b0 && int'(s) + 4 * int'(l) > 1024));
        if (range_bad) begin
            q.push_back(ev(0, 0, 1, 0, 0, 10'd0, 32'd0));
            q.push_back(ev(0, 0, 0, 0, 0, 10'd0, 32'd0));
        end else begin
            for (int i = 0; i < int'(l); i++) begin
                if (m == 1'b0) begin
                    w = ref_rd(10'(int'(s) + 4 * i));
                    q.push_back(ev(1, 0, 0, 1, 0, 10'(int'(s) + 4 * i), 32'd0));
                end else begin
                    w = f;
                end
                ref_wr(10'(int'(d) + 4 * i), w);
                q.push_back(ev(1, 0, 0, 0, 1, 10'(int'(d) + 4 * i), w));
            end
            q.push_back(ev(0, 1, 0, 0, 0, 10'd0, 32'd0));
        end
        @(negedge clk);
        start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = l; fill_data = f;
        foreach (q[i]) begin
            @(negedge clk);
            chk(tag, obs_vec(), q[i]);
            if (q[i][46] || q[i][45]) junk();
            else start = 1'b0;
        end
        mem_cmp({tag, "_mem"});
    endtask

    initial begin
        // Reset held with start activity: everything stays quiet.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("reset_outputs", {busy, done, err, mem_read, mem_write, mem_addr, mem_wrdata}, 47'd0);
            junk();
        end
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Abort in the middle of a 4-word copy.
        @(negedge clk);
        start = 1'b1; mode = 1'b0; src_addr = 10'h100; dst_addr = 10'h200; len = 8'd4;
        @(negedge clk);
        start = 1'b0;
        chk("abort_pre_busy", 47'({busy, mem_read}), 47'b11);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("abort_drop", 47'({busy, done, err, mem_read, mem_write}), 47'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", 47'({busy, done, mem_read, mem_write}), 47'd0);
        end
        rst = 1'b0;

        for (int a = 0; a < 1024; a += 4) poke(10'(a), $urandom);
        mem_cmp("init_mem");

        poke(10'h100, 32'h11223344);
        poke(10'h104, 32'h55667788);
        poke(10'h108, 32'h99AABBCC);
        poke(10'h10C, 32'hDDEEFF00);
        run_cmd("copy4", 1'b0, 10'h100, 10'h200, 8'd4, 32'h0);
        chk("copy4_w0", 47'(mem_rd(10'h200)), 47'h11223344);
        chk("copy4_w3", 47'(mem_rd(10'h20C)), 47'hDDEEFF00);

        run_cmd("fill_top", 1'b1, 10'h000, 10'h3F0, 8'd4, 32'hDEADBEEF);
        chk("fill_top_last", 47'(mem_rd(10'h3FC)), 47'hDEADBEEF);

        run_cmd("range_err", 1'b1, 10'h000, 10'h3FD, 8'd1, 32'h12345678);
        run_cmd("copy_len0", 1'b0, 10'h010, 10'h020, 8'd0, 32'h0);

        poke(10'h000, 32'hAAAA0001);
        poke(10'h004, 32'hBBBB0002);
        poke(10'h008, 32'hCCCC0003);
        run_cmd("overlap", 1'b0, 10'h000, 10'h004, 8'd3, 32'h0);
        chk("overlap_w4", 47'(mem_rd(10'h004)), 47'hAAAA0001);
        chk("overlap_w8", 47'(mem_rd(10'h008)), 47'hAAAA0001);
        chk("overlap_wc", 47'(mem_rd(10'h00C)), 47'hAAAA0001);

        for (int n = 0; n < 40; n++) begin
            bit          m;
            logic [7:0]  l;
            logic [9:0]  s, d;
            m = 1'($urandom_range(0, 1));
            l = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
            s = 10'($urandom);
            d = 10'($urandom);
            if ($urandom_range(0, 2) != 0) begin
                s = 10'($urandom_range(0, 1024 - 4 * int'(l)));
                d = 10'($urandom_range(0, 1024 - 4 * int'(l)));
            end
            run_cmd("random", m, s, d, l, $urandom);
        end

        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("final_idle", obs_vec(), 47'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
